// File: rtl/hex_tx_pkg.sv
// Shared types and byte constants for the hex word serializer.
package hex_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } hex_tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_word_tx_bin2ascii.sv
// Nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
module bin2ascii (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  always_comb begin
    if (nib < 4'd10) ascii = 8'h30 + {4'h0, nib};
    else             ascii = 8'h37 + {4'h0, nib};
  end

endmodule

// File: rtl/hex_word_tx.sv
// Serializes a WIDTH-bit word into ASCII hex digits, MS nibble first, with valid/ready.
// Optional CR/LF line terminator after each word when HEX_WORD_TX_NEWLINE_EN is defined.
module hex_word_tx
  import hex_tx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy
);

  localparam int NDIG  = WIDTH / 4;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  hex_tx_state_t    state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       digit_ascii;

  bin2ascii u_bin2ascii (
    .nib   (sreg[WIDTH-1:WIDTH-4]),
    .ascii (digit_ascii)
  );

  // sreg is cleared on reset so the idle output reads as digit '0'
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (word_valid) begin
            sreg  <= word;
            cnt   <= CNT_W'(NDIG - 1);
            state <= DIGIT;
          end
        end
        DIGIT: begin
          if (tx_ready) begin
            sreg <= sreg << 4;
            if (cnt == '0) begin
`ifdef HEX_WORD_TX_NEWLINE_EN
              state <= CR;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
`ifdef HEX_WORD_TX_NEWLINE_EN
        CR: if (tx_ready) state <= LF;
        LF: if (tx_ready) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_valid   = (state != IDLE);
  assign busy       = (state != IDLE);
  assign word_ready = (state == IDLE);

  always_comb begin
    tx_data = digit_ascii;
`ifdef HEX_WORD_TX_NEWLINE_EN
    if (state == CR) tx_data = ASCII_CR;
    if (state == LF) tx_data = ASCII_LF;
`endif
  end

endmodule

// File: tb/tb_hex_word_tx.sv
// Directed, table-driven bench for hex_word_tx at WIDTH=32 and WIDTH=8.
module tb_hex_word_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  logic [7:0]  word8 = '0;
  logic        word_valid8 = 1'b0;
  logic        word_ready8;
  logic [7:0]  tx_data8;
  logic        tx_valid8;
  logic        tx_ready8 = 1'b1;
  logic        busy8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_word_tx #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  hex_word_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .word(word8), .word_valid(word_valid8),
    .word_ready(word_ready8), .tx_data(tx_data8), .tx_valid(tx_valid8),
    .tx_ready(tx_ready8), .busy(busy8)
  );

  typedef struct {
    logic [31:0] w;
    bit          stall;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept a word on the next edge; the caller's clock is at a negedge.
  task automatic accept32(input logic [31:0] w);
    chk("word_ready before accept", word_ready, 1);
    word = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    chk("busy after accept", busy, 1);
    chk("word_ready after accept", word_ready, 0);
  endtask

  // Collect n digits, comparing each offered byte; stalls follow 1,0,0,1,0,0...
  task automatic collect32(input logic [63:0] exp, input int n, input bit stall);
    int idx = 0;
    int cyc = 0;
    int p = 0;
    bit r;
    while (idx < n && cyc < 64) begin
      chk("tx_valid during digits", tx_valid, 1);
      chk($sformatf("digit %0d", idx), tx_data, exp[63-8*idx -: 8]);
      r = stall ? (p % 3 == 0) : 1'b1;
      p++;
      tx_ready = r;
      @(negedge clk);
      if (r) idx++;
      cyc++;
    end
    tx_ready = 1'b1;
    chk("digits transferred", idx, n);
    if (!stall) chk("consecutive digit cycles", cyc, n);
  endtask

  task automatic finish32();
`ifdef HEX_WORD_TX_NEWLINE_EN
    chk("cr byte", tx_data, 8'h0D);
    chk("cr valid", tx_valid, 1);
    @(negedge clk);
    chk("lf byte", tx_data, 8'h0A);
    chk("lf valid", tx_valid, 1);
    @(negedge clk);
`endif
    chk("idle word_ready", word_ready, 1);
    chk("idle tx_valid", tx_valid, 0);
    chk("idle busy", busy, 0);
  endtask

  initial begin
    vecs[0] = '{w: 32'hDEADBEEF, stall: 1'b0, exp: 64'h4445414442454546};
    vecs[1] = '{w: 32'hDEADBEEF, stall: 1'b1, exp: 64'h4445414442454546};
    vecs[2] = '{w: 32'h0123ABCD, stall: 1'b0, exp: 64'h3031323341424344};
    vecs[3] = '{w: 32'h89ABCDEF, stall: 1'b1, exp: 64'h3839414243444546};
    vecs[4] = '{w: 32'h00000009, stall: 1'b0, exp: 64'h3030303030303039};

    #1;
    chk("reset tx_valid", tx_valid, 0);
    chk("reset word_ready", word_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset tx_data", tx_data, 8'h30);
    chk("reset tx_valid w8", tx_valid8, 0);
    chk("reset tx_data w8", tx_data8, 8'h30);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      accept32(vecs[i].w);
      collect32(vecs[i].exp, 8, vecs[i].stall);
      finish32();
      @(negedge clk);
    end

    // Back-to-back: second word offered while busy must wait for word_ready.
    accept32(32'h00000000);
    word = 32'hFFFFFFFF;
    word_valid = 1'b1;
    collect32(64'h3030303030303030, 8, 1'b0);
    finish32();
    @(negedge clk);
    word_valid = 1'b0;
    chk("b2b second accepted", busy, 1);
    collect32(64'h4646464646464646, 8, 1'b0);
    finish32();
    @(negedge clk);

    // Asynchronous reset mid-word discards the partial word.
    accept32(32'h12345678);
    collect32(64'h3132330000000000, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async reset tx_valid", tx_valid, 0);
    chk("async reset busy", busy, 0);
    chk("async reset tx_data", tx_data, 8'h30);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept32(32'h00000009);
    collect32(64'h3030303030303039, 8, 1'b0);
    finish32();
    @(negedge clk);

    // WIDTH=8 instance.
    chk("w8 word_ready", word_ready8, 1);
    word8 = 8'hA5;
    word_valid8 = 1'b1;
    @(negedge clk);
    word_valid8 = 1'b0;
    chk("w8 digit0 valid", tx_valid8, 1);
    chk("w8 digit0", tx_data8, 8'h41);
    @(negedge clk);
    chk("w8 digit1", tx_data8, 8'h35);
    @(negedge clk);
`ifdef HEX_WORD_TX_NEWLINE_EN
    chk("w8 cr", tx_data8, 8'h0D);
    @(negedge clk);
    chk("w8 lf", tx_data8, 8'h0A);
    @(negedge clk);
`endif
    chk("w8 idle tx_valid", tx_valid8, 0);
    chk("w8 idle word_ready", word_ready8, 1);
    chk("w8 idle busy", busy8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
